// File: rtl/pdm_audio_out_if.sv
// Sample stream handshake between an audio source and the PDM output stage.
// The source owns sample_in/sample_valid; the PDM block owns sample_ready.
interface pdm_audio_out_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_in, sample_valid, input sample_ready);
  modport slave  (input sample_in, sample_valid, output sample_ready);
endinterface

// File: rtl/pdm_audio_out.sv
// Buffered 16-bit audio sample stream to a 1-bit first-order sigma-delta PDM output.
// A small FIFO absorbs upstream jitter; a sample timer pops one sample per period.
module pdm_audio_out #(
  parameter int SAMPLE_PERIOD = 2268,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  pdm_audio_out_if.slave              bus,
  output logic                        pdm_out,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state, state_next;
  logic [15:0]   timer;
  logic [15:0]   acc;
  logic [15:0]   cur_sample;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          ready_en;
  logic          push, pop, fifo_empty, terminal;
  logic [15:0]   u;
  logic [16:0]   acc_sum;

  // ready_en keeps sample_ready low until the first edge after reset release
  assign fifo_empty       = (fifo_count == '0);
  assign bus.sample_ready = ready_en && (fifo_count < CW'(FIFO_DEPTH));
  assign push             = bus.sample_valid && bus.sample_ready;
  assign terminal         = (timer == 16'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    sample_tick = 1'b0;
    underrun    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (!fifo_empty) begin
          state_next = RUN;
          pop        = 1'b1;
        end
      end
      RUN: begin
        if (terminal) begin
          sample_tick = 1'b1;
          underrun    = fifo_empty;
          pop         = !fifo_empty;
        end
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO never takes a push, so push and pop always have room to coexist
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      cur_sample <= '0;
    end else begin
      if (state == RUN) begin
        timer <= terminal ? 16'd0 : timer + 16'd1;
      end else begin
        timer <= '0;
      end
      if (pop) cur_sample <= mem[rd_ptr];
    end
  end

  // PRIME plays mid-scale; the accumulator carries across sample changes
  assign u       = (state == PRIME) ? 16'h8000 : (cur_sample ^ 16'h8000);
  assign acc_sum = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else if (state == IDLE) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else begin
      acc     <= acc_sum[15:0];
      pdm_out <= acc_sum[16];
    end
  end

endmodule

// File: tb/tb_pdm_audio_out.sv
// Randomized bench for pdm_audio_out with a queue-based reference model
// and a few hand-computed scenarios that pin the model down.
module tb_pdm_audio_out;

  localparam int P  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk_100mhz = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pdm_out, sample_tick, underrun;
  logic [CW-1:0] fifo_count;

  pdm_audio_out_if bus ();

  pdm_audio_out #(.SAMPLE_PERIOD(P), .FIFO_DEPTH(D)) dut (
    .clk         (clk_100mhz),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus.slave),
    .pdm_out     (pdm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .fifo_count  (fifo_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          check_en = 1'b0;

  // Reference model: phase 0/1/2 = idle/prime/run, integer accumulator, queue FIFO
  int          m_phase;
  int          m_runcyc;
  int          m_acc;
  bit          m_pdm;
  bit          m_rdy_en;
  logic [15:0] m_cur;
  logic [15:0] m_q[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit modelTick();
    return (m_phase == 2) && ((m_runcyc % P) == P - 1);
  endfunction

  task automatic modelReset();
    m_phase = 0; m_runcyc = 0; m_acc = 0; m_pdm = 0; m_rdy_en = 0; m_cur = '0;
    m_q.delete();
  endtask

  task automatic modelStep();
    int qs, u, s;
    bit tick, pop, push;
    qs   = m_q.size();
    tick = modelTick();
    pop  = (m_phase == 1 && enable && qs > 0) || (tick && qs > 0);
    push = bus.sample_valid && m_rdy_en && (qs < D);
    u    = (m_phase == 1) ? 32768 : int'(m_cur ^ 16'h8000);
    if (m_phase == 0) begin
      m_acc = 0; m_pdm = 0;
    end else begin
      s = m_acc + u; m_pdm = (s >= 65536); m_acc = s % 65536;
    end
    if (pop)  m_cur = m_q.pop_front();
    if (push) m_q.push_back(bus.sample_in);
    case (m_phase)
      0: if (enable) m_phase = 1;
      1: if (!enable) m_phase = 0; else if (qs > 0) begin m_phase = 2; m_runcyc = 0; end
      default: if (!enable) m_phase = 0; else m_runcyc++;
    endcase
    m_rdy_en = 1;
  endtask

  always @(negedge clk_100mhz) begin
    if (check_en) begin
      checkOutput("pdm_out", int'(pdm_out), int'(m_pdm));
      checkOutput("sample_tick", int'(sample_tick), int'(modelTick()));
      checkOutput("underrun", int'(underrun), int'(modelTick() && m_q.size() == 0));
      checkOutput("fifo_count", int'(fifo_count), m_q.size());
      checkOutput("sample_ready", int'(bus.sample_ready), int'(m_rdy_en && m_q.size() < D));
    end
  end

  task automatic applyStimulus(input bit en, input bit vld, input logic [15:0] d);
    enable = en; bus.sample_valid = vld; bus.sample_in = d;
    @(posedge clk_100mhz);
    modelStep();
    #1;
  endtask

  task automatic doReset(input int delay_ns);
    check_en = 0; enable = 0; bus.sample_valid = 0; bus.sample_in = '0;
    #(delay_ns);
    rst_n = 0;
    #1;
    checkOutput("rst_pdm_out", int'(pdm_out), 0);
    checkOutput("rst_fifo_count", int'(fifo_count), 0);
    checkOutput("rst_sample_ready", int'(bus.sample_ready), 0);
    modelReset();
    repeat (2) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    rst_n = 1;
    #1;
    checkOutput("ready_before_first_edge", int'(bus.sample_ready), 0);
    @(posedge clk_100mhz);
    modelStep();
    #1;
    check_en = 1;
  endtask

  task automatic runAlternating(output logic [15:0] pat, output int ticks);
    applyStimulus(0, 1, 16'h0000);
    applyStimulus(1, 0, 16'h0000);
    applyStimulus(1, 0, 16'h0000);
    pat = '0; ticks = 0;
    for (int i = 0; i < 16; i++) begin
      pat[i] = pdm_out;
      ticks += int'(sample_tick);
      applyStimulus(1, 0, 16'h0000);
    end
  endtask

  initial begin
    logic [15:0] pat_a, pat_b;
    int ticks, ones, unders;
    bus.sample_valid = 0; bus.sample_in = '0;
    modelReset();

    // Fill with playback idle: only FIFO_DEPTH samples fit
    doReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 16'(16'h1000 + i));
    checkOutput("fill_count", int'(fifo_count), 4);
    checkOutput("fill_ready_low", int'(bus.sample_ready), 0);
    checkOutput("fill_pdm_zero", int'(pdm_out), 0);

    doReset(3);
    runAlternating(pat_a, ticks);
    checkOutput("midscale_pattern", int'(pat_a), 16'hAAAA);
    checkOutput("midscale_ticks", ticks, 2);

    // Unaligned reset mid-run, then the same scenario must replay identically
    doReset(3);
    runAlternating(pat_b, ticks);
    checkOutput("replay_pattern", int'(pat_b), int'(pat_a));

    doReset(4);
    applyStimulus(0, 1, 16'h7FFF);
    applyStimulus(0, 1, 16'h8000);
    applyStimulus(1, 0, 16'h0000);
    applyStimulus(1, 0, 16'h0000);
    applyStimulus(1, 0, 16'h0000);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(pdm_out);
      applyStimulus(1, 0, 16'h0000);
    end
    checkOutput("fullscale_ones", ones, 8);
    ones = 0; unders = 0;
    for (int i = 0; i < 16; i++) begin
      ones += int'(pdm_out);
      unders += int'(underrun);
      applyStimulus(1, 0, 16'h0000);
    end
    checkOutput("minscale_ones", ones, 0);
    checkOutput("underrun_pulses", unders, 2);
    checkOutput("underrun_count", int'(fifo_count), 0);

    doReset(5);
    applyStimulus(0, 1, 16'h1111);
    applyStimulus(1, 1, 16'h2222);
    checkOutput("count_before_swap", int'(fifo_count), 2);
    applyStimulus(1, 1, 16'h3333);
    checkOutput("push_pop_count", int'(fifo_count), 2);

    doReset(6);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'(16'h4000 + i));
    applyStimulus(1, 0, 16'h0000);
    checkOutput("full_ready_low", int'(bus.sample_ready), 0);
    applyStimulus(1, 1, 16'h5555);
    checkOutput("full_no_bypass", int'(fifo_count), 3);

    doReset(2);
    for (int i = 0; i < 3000; i++) begin
      int vld_pct;
      bit en;
      vld_pct = ((i / 250) % 3 == 0) ? 5 : (((i / 250) % 3 == 1) ? 20 : 60);
      en = ($urandom_range(99) < 97) ? 1'b1 : enable;
      if ($urandom_range(99) < 2) en = !enable;
      if (i == 1500) doReset(7);
      applyStimulus(en, $urandom_range(99) < vld_pct, 16'($urandom));
    end

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
